// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser and stability counter
// sharing one sample-tick prescaler; emits debounced level plus rise/fall strobes.
module debounce_multi #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CLK_DIV      = 1000000,
    parameter int unsigned STABLE_TICKS = 3,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic        RESET_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] sw,
    output logic [CHANNELS-1:0] db,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [DIV_W-1:0] div_cnt;

    // Shared sample prescaler; tick is decoded straight from the count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CNT_W-1:0]       cnt_q;
        logic                   db_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   s;

        assign s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sw[i]};
            end
        end

        // Any return to the current level discards progress toward a change.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q  <= '0;
                db_q   <= RESET_LEVEL;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s == db_q) begin
                    cnt_q <= '0;
                end else if (tick && (cnt_q == CNT_LAST)) begin
                    db_q   <= s;
                    cnt_q  <= '0;
                    rise_q <= s;
                    fall_q <= !s;
                end else if (tick) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign db[i]   = db_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: directed test-plan scenarios plus
// randomized switch activity compared every cycle against a behavioural model.
module tb_debounce_multi;

    localparam int CH  = 4;
    localparam int DIV = 4;
    localparam int ST  = 3;
    localparam int SY  = 2;
    localparam int LAT_MIN = SY + 1 + (ST - 1) * DIV;
    localparam int LAT_MAX = SY + ST * DIV;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] sw = '0;
    logic [CH-1:0] db, rise, fall;
    logic          tick;

    debounce_multi #(
        .CHANNELS(CH), .CLK_DIV(DIV), .STABLE_TICKS(ST),
        .SYNC_STAGES(SY), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .sw(sw),
        .db(db), .rise(rise), .fall(fall), .tick(tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural reference: sample pipeline, elapsed-cycle tick, and a tally of
    // consecutive sample ticks on which the synchronised input disagreed with db.
    logic [SY-1:0] m_pipe [CH];
    logic [CH-1:0] m_db = '0, m_rise = '0, m_fall = '0;
    int            m_agree_ticks [CH];
    int            m_phase = 0;

    int rise_cnt [CH];
    int fall_cnt [CH];
    int last_rise [CH];
    int last_fall [CH];
    int full_rise_cnt = 0;
    logic [CH-1:0] full_rise_db = '0;
    int first_tick = -1;
    int second_tick = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_pipe[c] = '0;
                m_agree_ticks[c] = 0;
            end
            m_db = '0; m_rise = '0; m_fall = '0;
            m_phase = 0;
        end else begin
            bit sample = (m_phase == DIV - 1);
            for (int c = 0; c < CH; c++) begin
                logic settled = m_pipe[c][SY-1];
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (settled == m_db[c]) begin
                    m_agree_ticks[c] = 0;
                end else if (sample) begin
                    m_agree_ticks[c] = m_agree_ticks[c] + 1;
                    if (m_agree_ticks[c] >= ST) begin
                        m_db[c] = settled;
                        m_rise[c] = settled;
                        m_fall[c] = !settled;
                        m_agree_ticks[c] = 0;
                    end
                end
                for (int k = SY - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
                m_pipe[c][0] = sw[c];
            end
            m_phase = (m_phase + 1) % DIV;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("db", 32'(db), 32'(m_db));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("tick", 32'(tick), 32'(m_phase == DIV - 1));
        for (int c = 0; c < CH; c++) begin
            if (rise[c]) begin rise_cnt[c]++; last_rise[c] = cyc; end
            if (fall[c]) begin fall_cnt[c]++; last_fall[c] = cyc; end
        end
        if (rise == '1) begin full_rise_cnt++; full_rise_db = db; end
        if (tick) begin
            if (first_tick < 0) first_tick = cyc;
            else if (second_tick < 0) second_tick = cyc;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Waits (bounded) for the next rise/fall on a channel and checks its latency.
    task automatic wait_edge(input int c, input bit rising, input int t0, input string tag);
        int base = rising ? rise_cnt[c] : fall_cnt[c];
        int n = 0;
        int lat;
        int lim;
        while ((rising ? rise_cnt[c] : fall_cnt[c]) == base && n < 40) begin
            step();
            n++;
        end
        if ((rising ? rise_cnt[c] : fall_cnt[c]) == base) lat = 999;
        else lat = (rising ? last_rise[c] : last_fall[c]) - t0;
        lim = (lat < LAT_MIN) ? LAT_MIN : ((lat > LAT_MAX) ? LAT_MAX : lat);
        chk(tag, 32'(lat), 32'(lim));
    endtask

    initial begin
        int t0;
        int r0;
        int f0;
        int rates [3] = '{4, 16, 40};
        for (int c = 0; c < CH; c++) begin
            m_pipe[c] = '0; m_agree_ticks[c] = 0;
            rise_cnt[c] = 0; fall_cnt[c] = 0; last_rise[c] = 0; last_fall[c] = 0;
        end

        reset = 1'b1; sw = '0;
        steps(3);
        chk("reset_db", 32'(db), 32'(0));
        chk("reset_strobes", 32'({rise, fall}), 32'(0));
        chk("reset_tick", 32'(tick), 32'(0));
        reset = 1'b0;
        steps(20);
        chk("idle_no_edges", 32'(rise_cnt[0] + fall_cnt[0] + rise_cnt[3]), 32'(0));

        // Clean press on channel 0
        t0 = cyc; sw[0] = 1'b1;
        wait_edge(0, 1'b1, t0, "press_latency");
        steps(10);
        chk("press_one_rise", 32'(rise_cnt[0]), 32'(1));
        chk("press_no_fall", 32'(fall_cnt[0]), 32'(0));
        chk("press_others_low", 32'(db[3:1]), 32'(0));

        // Glitch on channel 1
        sw[1] = 1'b1; steps(7); sw[1] = 1'b0;
        steps(30);
        chk("glitch_db", 32'(db[1]), 32'(0));
        chk("glitch_strobes", 32'(rise_cnt[1] + fall_cnt[1]), 32'(0));

        // Bounce on channel 2, then hold high
        for (int i = 0; i < 10; i++) begin
            sw[2] = ~sw[2];
            steps(3);
        end
        chk("bounce_no_rise", 32'(rise_cnt[2]), 32'(0));
        t0 = cyc; sw[2] = 1'b1;
        wait_edge(2, 1'b1, t0, "bounce_latency");
        steps(10);
        chk("bounce_one_rise", 32'(rise_cnt[2]), 32'(1));

        // Release channel 0
        r0 = rise_cnt[0];
        t0 = cyc; sw[0] = 1'b0;
        wait_edge(0, 1'b0, t0, "release_latency");
        steps(10);
        chk("release_one_fall", 32'(fall_cnt[0]), 32'(1));
        chk("release_no_rise", 32'(rise_cnt[0]), 32'(r0));

        sw = '0;
        steps(25);
        chk("settled_low", 32'(db), 32'(0));

        // Reset 9 edges into a press on channel 3
        sw[3] = 1'b1;
        steps(9);
        reset = 1'b1;
        step();
        chk("midreset_db3", 32'(db[3]), 32'(0));
        chk("midreset_tick", 32'(tick), 32'(0));
        reset = 1'b0;
        first_tick = -1; second_tick = -1;
        t0 = cyc;
        wait_edge(3, 1'b1, t0, "post_reset_latency");
        for (int i = 0; i < 10 && second_tick < 0; i++) step();
        chk("tick_period", 32'(second_tick - first_tick), 32'(DIV));

        sw = '0;
        steps(25);
        chk("settled_low2", 32'(db), 32'(0));

        // All channels at once
        full_rise_cnt = 0;
        r0 = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
        f0 = 0;
        sw = '1;
        steps(25);
        chk("simul_full_rise", 32'(full_rise_cnt), 32'(1));
        chk("simul_db_at_rise", 32'(full_rise_db), 32'(4'hF));
        chk("simul_total_rises", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3] - r0), 32'(4));

        // Randomized activity with occasional reset pulses
        for (int blk = 0; blk < 6; blk++) begin
            int rate = rates[$urandom_range(0, 2)];
            for (int i = 0; i < 500; i++) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, rate - 1) == 0) sw[c] = ~sw[c];
                reset = ($urandom_range(0, 399) == 0);
                step();
                f0 = f0 + 1;
            end
        end
        reset = 1'b0;
        steps(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
